// File: rtl/uart_rx_cfg_if.sv
// Receive-side result bundle of uart_rx_cfg.
//   data_out   : last received word (DATA_BITS wide)
//   valid_out  : one-cycle pulse, frame complete and flags updated
//   parity_err : parity mismatch of the last frame
//   frame_err  : a stop bit of the last frame was sampled low
//   break_det  : one-cycle pulse, break frame detected
//   busy       : receiver is not idle
// master = the receiver driving the bundle, slave = the consumer.
interface uart_rx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 valid_out;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;
  logic                 busy;

  modport master (
    output data_out, valid_out, parity_err, frame_err, break_det, busy
  );

  modport slave (
    input data_out, valid_out, parity_err, frame_err, break_det, busy
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Parametrised oversampling UART receiver (5..9 data bits, none/odd/even
// parity, 1 or 2 stop bits, LSB- or MSB-first).
//   clk, rst_n : system clock, asynchronous active-low reset
//   rx         : asynchronous serial line, idle high
//   tick_os    : single-cycle strobe at OVERSAMPLE x baud
//   rx_if      : result bundle (data_out, valid_out, parity_err, frame_err,
//                break_det, busy), driven through the master modport
module uart_rx_cfg #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned LSB_FIRST  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx,
  input  logic          tick_os,
  uart_rx_cfg_if.master rx_if
);

  localparam int unsigned TCNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BCNT_W = $clog2(DATA_BITS + 1);
  localparam logic [TCNT_W-1:0] T_LAST  = TCNT_W'(OVERSAMPLE - 1);
  localparam logic [TCNT_W-1:0] T_HALF  = TCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BCNT_W-1:0] B_DLAST = BCNT_W'(DATA_BITS - 1);
  localparam logic [BCNT_W-1:0] B_SLAST = BCNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT
  } state_t;

  logic                 r_rx_meta, r_rxs;
  state_t               r_state, w_state_nxt;
  logic [TCNT_W-1:0]    r_tcnt;
  logic [BCNT_W-1:0]    r_bcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_ferr_acc;
  logic                 r_stop0_low;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_valid, r_perr, r_ferr, r_brk, r_busy;

  logic w_t_last, w_t_half;
  logic w_sample, w_done, w_perr, w_ferr, w_brk, w_stop0_low;

  assign w_t_last = (r_tcnt == T_LAST);
  assign w_t_half = (r_tcnt == T_HALF);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; nothing moves without a tick
  always_comb begin
    w_state_nxt = r_state;
    if (tick_os) begin
      case (r_state)
        S_IDLE:   if (!r_rxs) w_state_nxt = S_START;
        S_START:  if (w_t_half) w_state_nxt = r_rxs ? S_IDLE : S_DATA;
        S_DATA:   if (w_t_last && (r_bcnt == B_DLAST))
                    w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
        S_PARITY: if (w_t_last) w_state_nxt = S_STOP;
        S_STOP:   if (w_t_last && (r_bcnt == B_SLAST))
                    w_state_nxt = r_rxs ? S_IDLE : S_WAIT;
        S_WAIT:   if (r_rxs) w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Frame-completion and flag decode for the last stop sample
  always_comb begin
    w_sample    = tick_os && w_t_last;
    w_done      = (r_state == S_STOP) && w_sample && (r_bcnt == B_SLAST);
    w_ferr      = r_ferr_acc | ~r_rxs;
    w_stop0_low = (r_bcnt == '0) ? ~r_rxs : r_stop0_low;
    w_perr      = 1'b0;
    if (PARITY == 1) w_perr = ~(^r_shift ^ r_par_bit);
    if (PARITY == 2) w_perr = ^r_shift ^ r_par_bit;
    w_brk = (r_shift == '0) && ((PARITY == 0) || !r_par_bit) && w_stop0_low;
  end

  // Synchroniser, counters, shift register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta   <= 1'b1;
      r_rxs       <= 1'b1;
      r_tcnt      <= '0;
      r_bcnt      <= '0;
      r_shift     <= '0;
      r_par_bit   <= 1'b0;
      r_ferr_acc  <= 1'b0;
      r_stop0_low <= 1'b0;
      r_data_out  <= '0;
      r_valid     <= 1'b0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_brk       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rxs     <= r_rx_meta;
      r_valid   <= w_done;
      r_brk     <= w_done && w_brk;
      r_busy    <= (w_state_nxt != S_IDLE);
      if (w_done) begin
        r_data_out <= r_shift;
        r_perr     <= w_perr;
        r_ferr     <= w_ferr;
      end
      if (tick_os) begin
        // Counters restart on every state change
        if (w_state_nxt != r_state)
          r_tcnt <= '0;
        else if (r_state inside {S_START, S_DATA, S_PARITY, S_STOP})
          r_tcnt <= w_t_last ? '0 : r_tcnt + 1'b1;
        if (w_state_nxt != r_state)
          r_bcnt <= '0;
        else if (w_sample && (r_state inside {S_DATA, S_STOP}))
          r_bcnt <= r_bcnt + 1'b1;
      end
      if (r_state == S_START) begin
        r_ferr_acc  <= 1'b0;
        r_stop0_low <= 1'b0;
      end
      if ((r_state == S_DATA) && w_sample) begin
        if (LSB_FIRST != 0) r_shift <= {r_rxs, r_shift[DATA_BITS-1:1]};
        else                r_shift <= {r_shift[DATA_BITS-2:0], r_rxs};
      end
      if ((r_state == S_PARITY) && w_sample) r_par_bit <= r_rxs;
      if ((r_state == S_STOP) && w_sample) begin
        r_ferr_acc <= r_ferr_acc | ~r_rxs;
        if (r_bcnt == '0) r_stop0_low <= ~r_rxs;
      end
    end
  end

  assign rx_if.data_out   = r_data_out;
  assign rx_if.valid_out  = r_valid;
  assign rx_if.parity_err = r_perr;
  assign rx_if.frame_err  = r_ferr;
  assign rx_if.break_det  = r_brk;
  assign rx_if.busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three receivers share clk and tick_os.
//   dut_a : 8N1, LSB first
//   dut_b : 7 data bits, even parity, 2 stop bits
//   dut_c : 9 data bits, no parity, 1 stop, MSB first, own reset
module tb_uart_rx_cfg;
  localparam int BIT_CLK = 64;  // 16 ticks x 4 clk

  logic clk = 1'b0;
  logic rst_ab, rst_c, tick;
  logic rx_a, rx_b, rx_c;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  uart_rx_cfg_if #(.DATA_BITS(8)) ifa ();
  uart_rx_cfg_if #(.DATA_BITS(7)) ifb ();
  uart_rx_cfg_if #(.DATA_BITS(9)) ifc ();

  uart_rx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16), .LSB_FIRST(1))
    dut_a (.clk(clk), .rst_n(rst_ab), .rx(rx_a), .tick_os(tick), .rx_if(ifa));
  uart_rx_cfg #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .OVERSAMPLE(16), .LSB_FIRST(1))
    dut_b (.clk(clk), .rst_n(rst_ab), .rx(rx_b), .tick_os(tick), .rx_if(ifb));
  uart_rx_cfg #(.DATA_BITS(9), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16), .LSB_FIRST(0))
    dut_c (.clk(clk), .rst_n(rst_c), .rx(rx_c), .tick_os(tick), .rx_if(ifc));

  // tick_os every 4 clk
  int tick_div = 0;
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_div = (tick_div + 1) % 4;
      tick = (tick_div == 0);
    end
  end

  // Per-DUT event monitors sampled on the falling edge
  int nv_a = 0, nb_a = 0, nflag_a = 0, nbusy_a = 0;
  logic [7:0] d_a = '0, dprev_a = '0;
  initial forever begin
    @(negedge clk);
    if (ifa.busy) nbusy_a++;
    if (ifa.break_det) nb_a++;
    if (ifa.valid_out) begin
      nv_a++;
      dprev_a = d_a;
      d_a = ifa.data_out;
      if (ifa.parity_err | ifa.frame_err | ifa.break_det) nflag_a++;
    end
  end

  int nv_b = 0, nb_b = 0;
  logic [6:0] d_b = '0;
  logic pe_b = 1'b0, fe_b = 1'b0;
  initial forever begin
    @(negedge clk);
    if (ifb.break_det) nb_b++;
    if (ifb.valid_out) begin
      nv_b++;
      d_b = ifb.data_out;
      pe_b = ifb.parity_err;
      fe_b = ifb.frame_err;
    end
  end

  int nv_c = 0;
  logic [8:0] d_c = '0;
  initial forever begin
    @(negedge clk);
    if (ifc.valid_out) begin
      nv_c++;
      d_c = ifc.data_out;
    end
  end

  function automatic logic [9:0] fr8(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  function automatic logic [10:0] frb(input logic [6:0] d, input logic p, input logic s2);
    return {s2, 1'b1, p, d, 1'b0};
  endfunction

  task automatic set_rx(input int sel, input logic v);
    case (sel)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // Shift out n line bits, bit 0 first, then leave the line idle high
  task automatic send(input int sel, input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_rx(sel, bits[i]);
      repeat (BIT_CLK) @(negedge clk);
    end
    set_rx(sel, 1'b1);
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({ifa.valid_out, ifa.parity_err, ifa.frame_err, ifa.break_det, ifa.busy} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags_a got %b want 00000",
        {ifa.valid_out, ifa.parity_err, ifa.frame_err, ifa.break_det, ifa.busy});
    end
    n_cmp++;
    if (ifa.data_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_data_a got %h want 00", ifa.data_out);
    end
    n_cmp++;
    if ({ifb.valid_out, ifb.busy, ifc.valid_out, ifc.busy} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags_bc got %b want 0000",
        {ifb.valid_out, ifb.busy, ifc.valid_out, ifc.busy});
    end
    n_cmp++;
    if (ifc.data_out !== 9'h000) begin
      n_fail++; $display("FAIL reset_data_c got %h want 000", ifc.data_out);
    end
  endtask

  task automatic test_back_to_back();
    int v0, f0;
    v0 = nv_a; f0 = nflag_a;
    send(0, 32'({fr8(8'h3C), fr8(8'hA5)}), 20);
    repeat (16) @(negedge clk);
    n_cmp++;
    if (nv_a - v0 !== 2) begin
      n_fail++; $display("FAIL b2b_count got %0d want 2", nv_a - v0);
    end
    n_cmp++;
    if (dprev_a !== 8'hA5) begin
      n_fail++; $display("FAIL b2b_first got %h want a5", dprev_a);
    end
    n_cmp++;
    if (d_a !== 8'h3C) begin
      n_fail++; $display("FAIL b2b_second got %h want 3c", d_a);
    end
    n_cmp++;
    if (nflag_a - f0 !== 0) begin
      n_fail++; $display("FAIL b2b_flags got %0d flagged frames want 0", nflag_a - f0);
    end
  endtask

  task automatic test_parity();
    send(1, 32'(frb(7'h41, 1'b0, 1'b1)), 11);
    repeat (16) @(negedge clk);
    n_cmp++;
    if ({nv_b, d_b, pe_b, fe_b} !== {32'd1, 7'h41, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL par_good got n=%0d d=%h pe=%b fe=%b want n=1 d=41 pe=0 fe=0",
        nv_b, d_b, pe_b, fe_b);
    end
    send(1, 32'(frb(7'h41, 1'b1, 1'b1)), 11);
    repeat (16) @(negedge clk);
    n_cmp++;
    if ({nv_b, d_b, pe_b, fe_b} !== {32'd2, 7'h41, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL par_bad got n=%0d d=%h pe=%b fe=%b want n=2 d=41 pe=1 fe=0",
        nv_b, d_b, pe_b, fe_b);
    end
  endtask

  task automatic test_stop2();
    send(1, 32'(frb(7'h55, 1'b0, 1'b0)), 11);
    repeat (32) @(negedge clk);
    n_cmp++;
    if ({nv_b, d_b, pe_b, fe_b} !== {32'd3, 7'h55, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL stop2 got n=%0d d=%h pe=%b fe=%b want n=3 d=55 pe=0 fe=1",
        nv_b, d_b, pe_b, fe_b);
    end
    n_cmp++;
    if (nb_b !== 0) begin
      n_fail++; $display("FAIL stop2_break got %0d want 0", nb_b);
    end
    n_cmp++;
    if (ifb.busy !== 1'b0) begin
      n_fail++; $display("FAIL stop2_idle busy got %b want 0", ifb.busy);
    end
  endtask

  task automatic test_break();
    int v0, b0, bu0;
    v0 = nv_a; b0 = nb_a; bu0 = nbusy_a;
    rx_a = 1'b0;
    repeat (3 * 10 * BIT_CLK) @(negedge clk);
    n_cmp++;
    if (ifa.busy !== 1'b1) begin
      n_fail++; $display("FAIL brk_busy_held got %b want 1", ifa.busy);
    end
    n_cmp++;
    if (nbusy_a - bu0 < 3 * 10 * BIT_CLK - 8) begin
      n_fail++; $display("FAIL brk_busy_cycles got %0d want >= %0d", nbusy_a - bu0, 3 * 10 * BIT_CLK - 8);
    end
    n_cmp++;
    if ({nv_a - v0, nb_a - b0} !== {32'd1, 32'd1}) begin
      n_fail++; $display("FAIL brk_count got valid=%0d break=%0d want 1 1", nv_a - v0, nb_a - b0);
    end
    n_cmp++;
    if ({d_a, ifa.frame_err} !== {8'h00, 1'b1}) begin
      n_fail++; $display("FAIL brk_word got d=%h fe=%b want d=00 fe=1", d_a, ifa.frame_err);
    end
    rx_a = 1'b1;
    repeat (32) @(negedge clk);
    n_cmp++;
    if (ifa.busy !== 1'b0) begin
      n_fail++; $display("FAIL brk_release busy got %b want 0", ifa.busy);
    end
    send(0, 32'(fr8(8'h12)), 10);
    repeat (16) @(negedge clk);
    n_cmp++;
    if ({nv_a - v0, nb_a - b0, d_a, ifa.frame_err} !== {32'd2, 32'd1, 8'h12, 1'b0}) begin
      n_fail++; $display("FAIL brk_next got valid=%0d break=%0d d=%h fe=%b want 2 1 12 0",
        nv_a - v0, nb_a - b0, d_a, ifa.frame_err);
    end
  endtask

  task automatic test_glitch();
    int v0, bu0;
    v0 = nv_a; bu0 = nbusy_a;
    rx_a = 1'b0;
    repeat (20) @(negedge clk);
    rx_a = 1'b1;
    repeat (100) @(negedge clk);
    n_cmp++;
    if (nv_a - v0 !== 0) begin
      n_fail++; $display("FAIL glitch_valid got %0d want 0", nv_a - v0);
    end
    n_cmp++;
    if (nbusy_a - bu0 !== 32) begin
      n_fail++; $display("FAIL glitch_busy_cycles got %0d want 32", nbusy_a - bu0);
    end
    n_cmp++;
    if (ifa.busy !== 1'b0) begin
      n_fail++; $display("FAIL glitch_idle busy got %b want 0", ifa.busy);
    end
  endtask

  task automatic test_msb_first();
    // Line order: start, 1,0,0,0,0,0,0,0,1, stop
    send(2, 32'h0000_0602, 11);
    repeat (16) @(negedge clk);
    n_cmp++;
    if ({nv_c, d_c} !== {32'd1, 9'h101}) begin
      n_fail++; $display("FAIL msb_word got n=%0d d=%h want n=1 d=101", nv_c, d_c);
    end
    n_cmp++;
    if (ifc.data_out !== 9'h101) begin
      n_fail++; $display("FAIL msb_hold got %h want 101", ifc.data_out);
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    v0 = nv_c;
    send(2, 32'h0000_001E, 5);
    n_cmp++;
    if (ifc.busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_busy got %b want 1", ifc.busy);
    end
    rst_c = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ifc.data_out, ifc.valid_out, ifc.frame_err, ifc.break_det, ifc.busy} !== 13'b0) begin
      n_fail++; $display("FAIL mid_reset got d=%h v=%b fe=%b brk=%b busy=%b want all 0",
        ifc.data_out, ifc.valid_out, ifc.frame_err, ifc.break_det, ifc.busy);
    end
    rst_c = 1'b1;
    repeat (12 * BIT_CLK) @(negedge clk);
    n_cmp++;
    if (nv_c - v0 !== 0) begin
      n_fail++; $display("FAIL mid_no_pulse got %0d want 0", nv_c - v0);
    end
  endtask

  initial begin
    rst_ab = 1'b0; rst_c = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    repeat (5) @(negedge clk);
    test_reset();
    rst_ab = 1'b1; rst_c = 1'b1;
    repeat (20) @(negedge clk);
    test_reset();
    test_back_to_back();
    test_parity();
    test_stop2();
    test_break();
    test_glitch();
    test_msb_first();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver and successor to the single-rate 8N1 receiver. It oversamples `rx` on a shared oversample tick and aligns to the centre of each bit from a validated start edge. Supports 5–9 data bits, none/odd/even parity, 1 or 2 stop bits, and LSB- or MSB-first order. It reports parity error, framing error and line break alongside each received word, and feeds the command/LED decode logic.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; 1 or 2.
- OVERSAMPLE, 16, `tick_os` pulses per bit period; even, minimum 4.
- LSB_FIRST, 1, 1 = first received data bit lands in `data_out[0]`; 0 = first received bit lands in `data_out[DATA_BITS-1]`.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset; one clock domain only
- rx  in  1  asynchronous serial line; idle high
- tick_os  in  1  single-cycle strobe at OVERSAMPLE x baud rate
- data_out  out  DATA_BITS  last received word
- valid_out  out  1  one-cycle pulse: frame complete, data_out and flags updated
- parity_err  out  1  parity mismatch for the last frame; low when PARITY = 0
- frame_err  out  1  a stop bit was sampled low in the last frame
- break_det  out  1  one-cycle pulse: break frame detected
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: `data_out` = 0; `valid_out`, `parity_err`, `frame_err`, `break_det`, `busy` = 0.
  - Synchroniser flops reset to 1; state = IDLE; counters = 0.
- `rx` passes a 2-flop synchroniser; all logic uses the synchronised value `rxs`.
  - Data latency from pin is 2 clk.
- Tick counter `tcnt` has width clog2(OVERSAMPLE) and advances only on `tick_os`.
  - Bit counter `bcnt` has width clog2(DATA_BITS+1).
- State IDLE:
  - On `tick_os` with `rxs` = 0: enter START, clear `tcnt`.
- State START:
  - Count ticks. At `tcnt` = OVERSAMPLE/2-1 on `tick_os` (start-bit centre):
    - if `rxs` = 0: enter DATA, clear `tcnt` and `bcnt`;
    - else: glitch, return to IDLE with no outputs.
- State DATA:
  - On `tick_os` at `tcnt` = OVERSAMPLE-1, sample `rxs` into the shift register and increment `bcnt`; `tcnt` wraps to 0.
  - LSB_FIRST = 1: shift right, new bit enters at the MSB.
  - LSB_FIRST = 0: shift left, new bit enters at the LSB.
  - After DATA_BITS samples: go to PARITY if PARITY != 0, else STOP.
- State PARITY:
  - Sample the parity bit at the next centre.
  - Error when XOR(data, parity bit) = 0 for odd, or = 1 for even.
- State STOP:
  - Sample STOP_BITS centres. The frame error flag is set if any sampled stop bit is low.
- Frame completion, on the clk of the last stop sample:
  - `valid_out` = 1 for one cycle;
  - `data_out`, `parity_err` and `frame_err` load simultaneously;
  - the flags hold until the next `valid_out`.
- Break: all data bits 0, parity bit 0 (if present), and first stop bit 0.
  - `break_det` pulses in the same cycle as `valid_out`, with `frame_err` = 1 and `data_out` = 0.
- After completion:
  - `rxs` = 1 → go to IDLE;
  - `rxs` = 0 → go to WAIT_IDLE, which holds until `rxs` = 1 on a `tick_os`, then IDLE.
  - A held-low line produces exactly one frame and no further frames.
- `tick_os` absent: state and counters freeze. No timeout.
- Reset asserted mid-frame: immediate return to the reset state. No `valid_out` for the partial frame.
- Back-to-back frames: a new start edge is accepted on the first `tick_os` after returning to IDLE.
  - The minimum-length stop bit is sufficient; no idle gap is required.
- `valid_out` has no backpressure. The consumer must sample it in the pulse cycle.

Test Plan:
- Defaults (8N1, OVERSAMPLE = 16, `tick_os` every 4 clk): send 0xA5 then 0x3C back-to-back.
  - Expect two `valid_out` pulses, `data_out` = 0xA5 then 0x3C, all flags 0.
- PARITY = 2, DATA_BITS = 7: send 0x41 with parity bit 0 → `parity_err` = 0. Send 0x41 with parity bit 1 → `valid_out` with `parity_err` = 1, `data_out` = 0x41.
- STOP_BITS = 2: send 0x55 with the second stop bit low → `frame_err` = 1, `data_out` = 0x55, `break_det` = 0.
- Hold `rx` low for 3 frame times then release:
  - Exactly one `valid_out` and one `break_det`, `data_out` = 0x00, `frame_err` = 1.
  - `busy` stays high until `rx` returns high.
  - A following 0x12 frame is received correctly.
- Drive a 5-tick low glitch on idle `rx` → no `valid_out`, state back to IDLE, `busy` pulses only during START.
- LSB_FIRST = 0, DATA_BITS = 9: send serial bits 1,0,0,0,0,0,0,0,1 → `data_out` = 9'h101. Assert `rst_n` low mid-frame → outputs return to 0 and there is no pulse.
